// File: rtl/jac_pkg.sv
// jac_pkg -- definitions shared by the fetch stage and the decoder.
//   fetch_state_t : fetch FSM encoding (IDLE/FLUSH/RUN/HALT)
//   NOP_INSTR     : instruction word presented while nothing executes
//   PC_WIDTH      : default program address width
//   Op_*          : opcode constants (instruction[15:12]) decoded downstream
package jac_pkg;

   localparam int PC_WIDTH           = 8;
   localparam int PROGRAM_DATA_WIDTH = 16;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   // opcode field lives in the top nibble of the instruction word
   localparam logic [3:0] Op_NOP   = 4'h0;
   localparam logic [3:0] Op_GOTO  = 4'h1;
   localparam logic [3:0] Op_CALL  = 4'h2;
   localparam logic [3:0] Op_RET   = 4'h3;
   localparam logic [3:0] Op_LOAD  = 4'h4;
   localparam logic [3:0] Op_STORE = 4'h5;
   localparam logic [3:0] Op_ADD   = 4'h6;
   localparam logic [3:0] Op_SUB   = 4'h7;

   function automatic logic [3:0] opcode_of(input logic [15:0] instr);
      return instr[15:12];
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit -- program counter and instruction-fetch stage.
// Drives a synchronous program ROM (1-cycle read latency) and presents one
// instruction per cycle to the decoder. A taken GOTO costs one bubble.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               1 = fetch/execute, 0 = park in IDLE
//   stall             freeze the whole stage (held instruction stays stable)
//   prog_adr/rd_en    ROM read address / enable (rd_en=0 keeps ROM output)
//   prog_data         ROM data, one cycle after the address
//   instruction       prog_data when instr_valid, NOP otherwise
//   instr_valid, pc   instruction executes this cycle, and its address
//   cnt_wr_en         decoder requests jump to literal_adr
//   bp_en, bp_adr,    (JAC_FETCH_BREAKPOINT_EN only) address breakpoint,
//   halted            halted while parked on a breakpoint
// Optional feature macro: JAC_FETCH_BREAKPOINT_EN
module fetch_unit #(
   parameter int PC_WIDTH          = jac_pkg::PC_WIDTH,
   parameter int PROGRAM_DataWidth = jac_pkg::PROGRAM_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   input  logic                         stall,
   output logic [PC_WIDTH-1:0]          prog_adr,
   output logic                         prog_rd_en,
   input  logic [PROGRAM_DataWidth-1:0] prog_data,
   output logic [PROGRAM_DataWidth-1:0] instruction,
   output logic                         instr_valid,
   output logic [PC_WIDTH-1:0]          pc,
   input  logic                         cnt_wr_en,
   input  logic [PC_WIDTH-1:0]          literal_adr
`ifdef JAC_FETCH_BREAKPOINT_EN
   ,
   input  logic                         bp_en,
   input  logic [PC_WIDTH-1:0]          bp_adr,
   output logic                         halted
`endif
);
   import jac_pkg::*;

   fetch_state_t        state_q, state_d;
   logic [PC_WIDTH-1:0] fetch_adr_q, fetch_adr_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                valid_q, valid_d;
   logic                rd_en;
   logic                load_req;
   logic                bp_hit;

`ifdef JAC_FETCH_BREAKPOINT_EN
   logic bp_skip_q;

   // bp_skip lets the resume after a breakpoint fetch the matching address once
   always_ff @(posedge clk) begin
      if (rst)
         bp_skip_q <= 1'b0;
      else if (!stall) begin
         if (state_q == HALT && !run)
            bp_skip_q <= 1'b1;
         else if (rd_en)
            bp_skip_q <= 1'b0;
      end
   end

   assign bp_hit = bp_en && (fetch_adr_q == bp_adr) && !bp_skip_q;
   assign halted = (state_q == HALT);
`else
   assign bp_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      fetch_adr_d = fetch_adr_q;
      pc_d        = pc_q;
      valid_d     = valid_q;
      rd_en       = 1'b0;
      load_req    = 1'b0;

      if (!stall) begin
         case (state_q)
            IDLE:  load_req = run;
            FLUSH: load_req = 1'b1;   // fetch the jump target
            RUN: begin
               if (cnt_wr_en && valid_q) begin
                  // the sequential address already on prog_adr is dropped
                  fetch_adr_d = literal_adr;
                  valid_d     = 1'b0;
                  if (run)
                     state_d = FLUSH;
                  else begin
                     pc_d    = literal_adr;
                     state_d = IDLE;
                  end
               end else if (!run) begin
                  // current instruction still executes; fetch_adr is the
                  // next unexecuted address, re-read on resume
                  pc_d    = fetch_adr_q;
                  valid_d = 1'b0;
                  state_d = IDLE;
               end else
                  load_req = 1'b1;
            end
`ifdef JAC_FETCH_BREAKPOINT_EN
            HALT: if (!run) state_d = IDLE;
`endif
            default: state_d = IDLE;
         endcase

         if (load_req) begin
            if (bp_hit) begin
               valid_d = 1'b0;
               state_d = HALT;
            end else begin
               pc_d        = fetch_adr_q;
               fetch_adr_d = fetch_adr_q + PC_WIDTH'(1);
               valid_d     = 1'b1;
               state_d     = RUN;
               rd_en       = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fetch_adr_q <= '0;
         pc_q        <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_adr_q <= fetch_adr_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
      end
   end

   // gated so the ROM is not read while reset is held
   assign prog_rd_en  = rd_en && !rst;
   assign prog_adr    = fetch_adr_q;
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign instruction = valid_q ? prog_data : PROGRAM_DataWidth'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- scoreboard bench for fetch_unit. Stimulus pushes the
// expected executed (pc, instruction) stream; a negedge monitor pops and
// compares each executed instruction. ROM[i] = i + 16'h0100.
module tb_fetch_unit;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, run, stall, cnt_wr_en;
   logic [7:0]  literal_adr;
   logic [7:0]  prog_adr, pc;
   logic        prog_rd_en, instr_valid;
   logic [15:0] prog_data, instruction;
`ifdef JAC_FETCH_BREAKPOINT_EN
   logic        bp_en;
   logic [7:0]  bp_adr;
   logic        halted;
`endif

   logic [15:0] rom [256];
   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
      .clk(clk), .rst(rst), .run(run), .stall(stall),
      .prog_adr(prog_adr), .prog_rd_en(prog_rd_en), .prog_data(prog_data),
      .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
      .cnt_wr_en(cnt_wr_en), .literal_adr(literal_adr)
`ifdef JAC_FETCH_BREAKPOINT_EN
      , .bp_en(bp_en), .bp_adr(bp_adr), .halted(halted)
`endif
   );

   initial for (int i = 0; i < 256; i++) rom[i] = 16'(i) + 16'h0100;

   // synchronous ROM with output register hold
   always @(posedge clk) if (prog_rd_en) prog_data <= rom[prog_adr];

   // monitor: an instruction executes in a valid, non-stalled cycle
   always @(negedge clk) begin
      if (instr_valid === 1'b1 && stall === 1'b0) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_exec: got pc=%h instr=%h, required none", pc, instruction);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (pc !== e.pc || instruction !== e.instr) begin
               bad++;
               $display("FAIL exec_stream: got pc=%h instr=%h, required pc=%h instr=%h",
                        pc, instruction, e.pc, e.instr);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] p, input logic [15:0] ins);
      exp_t e;
      e.pc = p; e.instr = ins;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // advance until pc==target is presented valid, with a cycle budget
   task automatic wait_pc(input logic [7:0] target);
      bit hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step();
         if (instr_valid === 1'b1 && pc === target) hit = 1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL wait_pc_timeout: got pc=%h, required pc=%h", pc, target);
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; stall = 1'b0; cnt_wr_en = 1'b0; literal_adr = 8'h00;
`ifdef JAC_FETCH_BREAKPOINT_EN
      bp_en = 1'b0; bp_adr = 8'h00;
`endif
      step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_adr", 32'(prog_adr), 32'h0);
      chk("rst_rd_en", 32'(prog_rd_en), 32'h0);
      chk("rst_instr", 32'(instruction), 32'h0);

      // T1: sequential fetch from 0
      for (int i = 0; i < 4; i++) push(8'(i), 16'h0100 + 16'(i));
      run = 1'b1;
      step();
      chk("t1_first_pc", 32'(pc), 32'h0);
      chk("t1_first_instr", 32'(instruction), 32'h0100);
      wait_pc(8'h03);

      // T2: GOTO 0x20 while pc=3 is executing
      cnt_wr_en = 1'b1; literal_adr = 8'h20;
      #1 chk("t2_jump_rd_en", 32'(prog_rd_en), 32'h0);
      step();
      cnt_wr_en = 1'b0;
      chk("t2_bubble_valid", 32'(instr_valid), 32'h0);
      chk("t2_bubble_nop", 32'(instruction), 32'h0);
      push(8'h20, 16'h0120); push(8'h21, 16'h0121); push(8'h22, 16'h0122);
      step();
      chk("t2_target_pc", 32'(pc), 32'h20);
      wait_pc(8'h22);

      // T3: stall 3 cycles at 0x22 with a GOTO 5 pending across the stall
      stall = 1'b1; cnt_wr_en = 1'b1; literal_adr = 8'h05;
      #1 chk("t3_stall_rd_en", 32'(prog_rd_en), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_stall_pc", 32'(pc), 32'h22);
         chk("t3_stall_instr", 32'(instruction), 32'h0122);
         chk("t3_stall_valid", 32'(instr_valid), 32'h1);
      end
      stall = 1'b0;
      push(8'h05, 16'h0105); push(8'h06, 16'h0106); push(8'h07, 16'h0107);
      step();
      cnt_wr_en = 1'b0;
      chk("t3_bubble_valid", 32'(instr_valid), 32'h0);
      step();
      chk("t3_target_pc", 32'(pc), 32'h05);
      wait_pc(8'h07);

      // T5: drop run at pc=7, resume at 8 without skip or duplicate
      run = 1'b0;
      step();
      chk("t5_idle_valid", 32'(instr_valid), 32'h0);
      step();
      chk("t5_idle_rd_en", 32'(prog_rd_en), 32'h0);
      chk("t5_idle_instr", 32'(instruction), 32'h0);
      push(8'h08, 16'h0108); push(8'h09, 16'h0109);
      run = 1'b1;
      step();
      chk("t5_resume_pc", 32'(pc), 32'h08);
      wait_pc(8'h09);

      // T4: jump to 0xFE, wrap through 0xFF -> 0x00 with no bubble
      cnt_wr_en = 1'b1; literal_adr = 8'hFE;
      push(8'hFE, 16'h01FE); push(8'hFF, 16'h01FF); push(8'h00, 16'h0100); push(8'h01, 16'h0101);
      step();
      cnt_wr_en = 1'b0;
      step();
      chk("t4_pc_fe", 32'(pc), 32'hFE);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_no_bubble", 32'(instr_valid), 32'h1);
      end
      chk("t4_wrap_pc", 32'(pc), 32'h01);

      // T5b: reset mid-RUN
      rst = 1'b1;
      step();
      chk("mid_rst_valid", 32'(instr_valid), 32'h0);
      chk("mid_rst_pc", 32'(pc), 32'h0);
      chk("mid_rst_adr", 32'(prog_adr), 32'h0);
      chk("mid_rst_rd_en", 32'(prog_rd_en), 32'h0);
      chk("mid_rst_instr", 32'(instruction), 32'h0);
      rst = 1'b0;
      push(8'h00, 16'h0100); push(8'h01, 16'h0101); push(8'h02, 16'h0102);
      wait_pc(8'h02);

`ifdef JAC_FETCH_BREAKPOINT_EN
      // T6: breakpoint on 0x04, resume executes 4 exactly once
      bp_en = 1'b1; bp_adr = 8'h04;
      push(8'h03, 16'h0103);
      wait_pc(8'h03);
      step();
      chk("t6_halted", 32'(halted), 32'h1);
      chk("t6_halt_valid", 32'(instr_valid), 32'h0);
      chk("t6_halt_rd_en", 32'(prog_rd_en), 32'h0);
      step();
      chk("t6_still_halted", 32'(halted), 32'h1);
      run = 1'b0;
      step();
      chk("t6_unhalted", 32'(halted), 32'h0);
      push(8'h04, 16'h0104); push(8'h05, 16'h0105);
      run = 1'b1;
      wait_pc(8'h05);
`endif

      run = 1'b0;
      step(); step(); step();
      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
